// File: rtl/sram_arb_pkg.sv
// Shared definitions for the sram bus arbiter: master ids, size codes and
// the request control payload that travels alongside address and write data.
package sram_arb_pkg;

    localparam logic M_INST = 1'b0;
    localparam logic M_DATA = 1'b1;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef struct packed {
        logic       wr;
        logic [1:0] size;
        logic [3:0] wstrb;
    } req_ctrl_t;

    localparam int REQ_CTRL_W = $bits(req_ctrl_t);

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// One sram-like req/addr_ok/data_ok channel; the master modport is the side
// that issues requests, the slave modport is the side that answers them.
interface sram_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/arb_order_fifo.sv
// 1-bit-wide in-order FIFO recording which master owns each outstanding request.
// full/empty come from the registered count, so a same-cycle pop never frees a slot early.
module arb_order_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == (PTR_W+1)'(0));
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like bus between fetch (inst) and execute (data) ports with in-order responses.
// Optional SRAM_ARB_RR_EN: round-robin between masters instead of fixed data-over-inst priority.
module sram_bus_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int OUTST_N = 4
) (
    input  logic                clk,
    input  logic                rstn,
    sram_bus_arbiter_if.slave   inst,
    sram_bus_arbiter_if.slave   data,
    sram_bus_arbiter_if.master  sram
);
    logic      lock_valid_q, lock_valid_d;
    logic      lock_id_q, lock_id_d;
    logic      winner_s, winner_req_s, sram_req_s;
    logic      push_s, pop_s, resp_valid_s;
    logic      fifo_head_s, fifo_full_s, fifo_empty_s;
    req_ctrl_t ctrl_s;

`ifdef SRAM_ARB_RR_EN
    logic last_q, last_d;

    // Winner selection: a held lock wins, otherwise the master not granted last.
    always_comb begin
        if (lock_valid_q) begin
            winner_s = lock_id_q;
        end else if (inst.req && data.req) begin
            winner_s = ~last_q;
        end else if (data.req) begin
            winner_s = M_DATA;
        end else begin
            winner_s = M_INST;
        end
        last_d = push_s ? winner_s : last_q;
    end

    // Last-grant pointer register.
    always_ff @(posedge clk) begin
        if (!rstn) last_q <= M_INST;
        else       last_q <= last_d;
    end
`else
    // Winner selection: a held lock wins, otherwise data beats inst.
    always_comb begin
        if (lock_valid_q) begin
            winner_s = lock_id_q;
        end else if (data.req) begin
            winner_s = M_DATA;
        end else begin
            winner_s = M_INST;
        end
    end
`endif

    // Request gating, lock update and FIFO push/pop qualification.
    always_comb begin
        winner_req_s = (winner_s == M_DATA) ? data.req : inst.req;
        sram_req_s   = winner_req_s && !fifo_full_s;
        push_s       = sram_req_s && sram.addr_ok;
        pop_s        = sram.data_ok && !fifo_empty_s;
        resp_valid_s = pop_s;
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        if (sram_req_s && !sram.addr_ok) begin
            lock_valid_d = 1'b1;
            lock_id_d    = winner_s;
        end else if (push_s) begin
            lock_valid_d = 1'b0;
        end else begin
            lock_valid_d = lock_valid_q;
        end
    end

    // Grant lock register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lock_valid_q <= 1'b0;
            lock_id_q    <= M_INST;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
        end
    end

    assign ctrl_s = (winner_s == M_DATA) ? '{wr: data.wr, size: data.size, wstrb: data.wstrb}
                                         : '{wr: inst.wr, size: inst.size, wstrb: inst.wstrb};

    assign sram.req   = sram_req_s;
    assign sram.wr    = ctrl_s.wr;
    assign sram.size  = ctrl_s.size;
    assign sram.wstrb = ctrl_s.wstrb;
    assign sram.addr  = (winner_s == M_DATA) ? data.addr  : inst.addr;
    assign sram.wdata = (winner_s == M_DATA) ? data.wdata : inst.wdata;

    assign inst.addr_ok = push_s && (winner_s == M_INST);
    assign data.addr_ok = push_s && (winner_s == M_DATA);

    // Responses follow the FIFO head; stray data_ok with nothing outstanding is dropped.
    assign inst.data_ok = resp_valid_s && (fifo_head_s == M_INST);
    assign data.data_ok = resp_valid_s && (fifo_head_s == M_DATA);
    assign inst.rdata   = inst.data_ok ? sram.rdata : {DATA_W{1'b0}};
    assign data.rdata   = data.data_ok ? sram.rdata : {DATA_W{1'b0}};

    arb_order_fifo #(.DEPTH(OUTST_N)) u_order_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (push_s),
        .push_id (winner_s),
        .pop     (pop_s),
        .head    (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: scoreboard of expected (owner, rdata) per issued request.
module tb_sram_bus_arbiter;
    import sram_arb_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_bus ();
    sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();
    sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) sram_bus ();

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTST_N(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .inst (inst_bus),
        .data (data_bus),
        .sram (sram_bus)
    );

    typedef struct { logic id; logic [31:0] rdata; } exp_t;
    typedef struct packed {
        logic i_aok; logic i_dok; logic [31:0] i_rd;
        logic d_aok; logic d_dok; logic [31:0] d_rd;
        logic s_req; logic [31:0] s_addr;
    } obs_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef SRAM_ARB_RR_EN
    localparam logic PRIO_WIN = M_INST;
`else
    localparam logic PRIO_WIN = M_DATA;
`endif

    task automatic set_inst(input logic r, input logic [31:0] a);
        inst_bus.req = r; inst_bus.addr = a; inst_bus.wr = 1'b0;
        inst_bus.size = SZ_W; inst_bus.wstrb = 4'hf; inst_bus.wdata = 32'h0;
    endtask

    task automatic set_data(input logic r, input logic [31:0] a, input logic w);
        data_bus.req = r; data_bus.addr = a; data_bus.wr = w;
        data_bus.size = SZ_W; data_bus.wstrb = 4'hf; data_bus.wdata = a ^ 32'h5a5a_5a5a;
    endtask

    task automatic set_slave(input logic aok, input logic dok, input logic [31:0] rd);
        sram_bus.addr_ok = aok; sram_bus.data_ok = dok; sram_bus.rdata = rd;
    endtask

    // Sample on the falling edge, then advance to just after the next rising edge.
    task automatic cyc(output obs_t o);
        @(negedge clk);
        o = '{inst_bus.addr_ok, inst_bus.data_ok, inst_bus.rdata,
              data_bus.addr_ok, data_bus.data_ok, data_bus.rdata,
              sram_bus.req, sram_bus.addr};
        @(posedge clk);
        #1;
    endtask

    // Slave returns the oldest planned response; the popped entry is what the test compares against.
    task automatic drive_resp(input logic aok, output obs_t o, output exp_t e);
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_underflow: got empty queue, required an outstanding entry");
            e = '{M_INST, 32'h0};
        end else begin
            e = exp_q.pop_front();
        end
        set_slave(aok, 1'b1, e.rdata);
        cyc(o);
        set_slave(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        obs_t o;
        rstn = 1'b0;
        set_inst(1'b0, 32'h0); set_data(1'b0, 32'h0, 1'b0); set_slave(1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        cyc(o);
        checks++;
        if (o !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h, required 0", o);
        end
        rstn = 1'b1;
        set_slave(1'b0, 1'b1, 32'hdead_beef);
        cyc(o);
        checks++;
        if ({o.i_dok, o.d_dok, o.i_rd, o.d_rd, o.s_req} !== '0) begin
            errors++; $display("FAIL stray_data_ok: got %h, required 0", o);
        end
        set_slave(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_single();
        obs_t o; exp_t e;
        set_data(1'b1, 32'h0000_8000, 1'b0); set_slave(1'b1, 1'b0, 32'h0);
        cyc(o);
        checks++;
        if ({o.d_aok, o.i_aok, o.s_req, o.s_addr} !== {1'b1, 1'b0, 1'b1, 32'h0000_8000}) begin
            errors++; $display("FAIL single_addr: got daok=%b iaok=%b req=%b addr=%h, required 1 0 1 00008000",
                               o.d_aok, o.i_aok, o.s_req, o.s_addr);
        end
        exp_q.push_back('{M_DATA, 32'h1234_5678});
        set_data(1'b0, 32'h0, 1'b0); set_slave(1'b0, 1'b0, 32'h0);
        cyc(o);
        checks++;
        if ({o.i_aok, o.i_dok, o.d_aok, o.d_dok, o.s_req} !== 5'b0) begin
            errors++; $display("FAIL single_idle: got %b, required 00000", {o.i_aok, o.i_dok, o.d_aok, o.d_dok, o.s_req});
        end
        drive_resp(1'b0, o, e);
        checks++;
        if ({o.i_dok, o.d_dok, o.i_rd, o.d_rd} !== {~e.id, e.id, e.id ? 32'h0 : e.rdata, e.id ? e.rdata : 32'h0}) begin
            errors++; $display("FAIL single_resp: got iok=%b dok=%b ir=%h dr=%h, required id=%b rdata=%h",
                               o.i_dok, o.d_dok, o.i_rd, o.d_rd, e.id, e.rdata);
        end
    endtask

    task automatic test_priority();
        obs_t o; exp_t e;
        logic [31:0] wa, la;
        wa = (PRIO_WIN == M_DATA) ? 32'h0000_8000 : 32'h1c00_0000;
        la = (PRIO_WIN == M_DATA) ? 32'h1c00_0000 : 32'h0000_8000;
        set_inst(1'b1, 32'h1c00_0000); set_data(1'b1, 32'h0000_8000, 1'b0); set_slave(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(o);
            checks++;
            if ({o.s_req, o.s_addr, o.i_aok, o.d_aok} !== {1'b1, wa, 2'b00}) begin
                errors++; $display("FAIL prio_wait%0d: got req=%b addr=%h iaok=%b daok=%b, required 1 %h 0 0",
                                   i, o.s_req, o.s_addr, o.i_aok, o.d_aok, wa);
            end
        end
        set_slave(1'b1, 1'b0, 32'h0);
        cyc(o);
        checks++;
        if ({o.s_addr, o.i_aok, o.d_aok} !== {wa, ~PRIO_WIN, PRIO_WIN}) begin
            errors++; $display("FAIL prio_accept: got addr=%h iaok=%b daok=%b, required %h winner=%b",
                               o.s_addr, o.i_aok, o.d_aok, wa, PRIO_WIN);
        end
        exp_q.push_back('{PRIO_WIN, 32'ha0a0_0001});
        if (PRIO_WIN == M_DATA) set_data(1'b0, 32'h0, 1'b0);
        else                    set_inst(1'b0, 32'h0);
        cyc(o);
        checks++;
        if ({o.s_addr, o.i_aok, o.d_aok} !== {la, PRIO_WIN, ~PRIO_WIN}) begin
            errors++; $display("FAIL prio_second: got addr=%h iaok=%b daok=%b, required %h loser=%b",
                               o.s_addr, o.i_aok, o.d_aok, la, ~PRIO_WIN);
        end
        exp_q.push_back('{~PRIO_WIN, 32'hb0b0_0002});
        set_inst(1'b0, 32'h0); set_data(1'b0, 32'h0, 1'b0); set_slave(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            drive_resp(1'b0, o, e);
            checks++;
            if ({o.i_dok, o.d_dok, o.i_rd, o.d_rd} !== {~e.id, e.id, e.id ? 32'h0 : e.rdata, e.id ? e.rdata : 32'h0}) begin
                errors++; $display("FAIL prio_resp%0d: got iok=%b dok=%b ir=%h dr=%h, required id=%b rdata=%h",
                                   i, o.i_dok, o.d_dok, o.i_rd, o.d_rd, e.id, e.rdata);
            end
        end
    endtask

    task automatic test_order();
        obs_t o; exp_t e;
        set_inst(1'b1, 32'h1c00_0000); set_slave(1'b0, 1'b0, 32'h0);
        cyc(o);
        set_data(1'b1, 32'h0000_8000, 1'b0); set_slave(1'b1, 1'b0, 32'h0);
        cyc(o);
        checks++;
        if ({o.s_addr, o.i_aok, o.d_aok} !== {32'h1c00_0000, 2'b10}) begin
            errors++; $display("FAIL lock_no_preempt: got addr=%h iaok=%b daok=%b, required 1c000000 1 0",
                               o.s_addr, o.i_aok, o.d_aok);
        end
        exp_q.push_back('{M_INST, 32'haaaa_5555});
        set_inst(1'b0, 32'h0);
        cyc(o);
        checks++;
        if ({o.s_addr, o.i_aok, o.d_aok} !== {32'h0000_8000, 2'b01}) begin
            errors++; $display("FAIL order_issue_b: got addr=%h iaok=%b daok=%b, required 00008000 0 1",
                               o.s_addr, o.i_aok, o.d_aok);
        end
        exp_q.push_back('{M_DATA, 32'h5555_aaaa});
        set_data(1'b0, 32'h0, 1'b0); set_slave(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            drive_resp(1'b0, o, e);
            checks++;
            if ({o.i_dok, o.d_dok, o.i_rd, o.d_rd} !== {~e.id, e.id, e.id ? 32'h0 : e.rdata, e.id ? e.rdata : 32'h0}) begin
                errors++; $display("FAIL order_resp%0d: got iok=%b dok=%b ir=%h dr=%h, required id=%b rdata=%h",
                                   i, o.i_dok, o.d_dok, o.i_rd, o.d_rd, e.id, e.rdata);
            end
        end
    endtask

    task automatic test_full();
        obs_t o; exp_t e;
        for (int k = 0; k < 4; k++) begin
            set_data(1'b1, 32'h0000_1000 + 32'(k * 4), 1'(k % 2)); set_slave(1'b1, 1'b0, 32'h0);
            cyc(o);
            checks++;
            if ({o.s_req, o.d_aok} !== 2'b11) begin
                errors++; $display("FAIL full_fill%0d: got req=%b daok=%b, required 1 1", k, o.s_req, o.d_aok);
            end
            exp_q.push_back('{M_DATA, 32'hc000_0000 + 32'(k)});
        end
        set_data(1'b1, 32'h0000_2000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(o);
            checks++;
            if ({o.s_req, o.d_aok} !== 2'b00) begin
                errors++; $display("FAIL full_block%0d: got req=%b daok=%b, required 0 0", i, o.s_req, o.d_aok);
            end
        end
        drive_resp(1'b1, o, e);
        checks++;
        if ({o.s_req, o.d_aok, o.i_dok, o.d_dok, o.d_rd} !== {2'b00, ~e.id, e.id, e.rdata}) begin
            errors++; $display("FAIL full_pop_cycle: got req=%b daok=%b dok=%b dr=%h, required 0 0 1 %h",
                               o.s_req, o.d_aok, o.d_dok, o.d_rd, e.rdata);
        end
        set_slave(1'b1, 1'b0, 32'h0);
        cyc(o);
        checks++;
        if ({o.s_req, o.d_aok, o.s_addr} !== {2'b11, 32'h0000_2000}) begin
            errors++; $display("FAIL full_reissue: got req=%b daok=%b addr=%h, required 1 1 00002000",
                               o.s_req, o.d_aok, o.s_addr);
        end
        exp_q.push_back('{M_DATA, 32'hc000_0004});
        set_data(1'b0, 32'h0, 1'b0); set_slave(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive_resp(1'b0, o, e);
            checks++;
            if ({o.i_dok, o.d_dok, o.i_rd, o.d_rd} !== {~e.id, e.id, e.id ? 32'h0 : e.rdata, e.id ? e.rdata : 32'h0}) begin
                errors++; $display("FAIL full_drain%0d: got iok=%b dok=%b ir=%h dr=%h, required id=%b rdata=%h",
                                   i, o.i_dok, o.d_dok, o.i_rd, o.d_rd, e.id, e.rdata);
            end
        end
    endtask

    task automatic test_push_pop();
        obs_t o; exp_t e;
        logic nid;
        set_slave(1'b1, 1'b0, 32'h0);
        set_inst(1'b1, 32'h1c00_0010); cyc(o); exp_q.push_back('{M_INST, 32'hd000_0000});
        set_inst(1'b0, 32'h0);
        set_data(1'b1, 32'h0000_8010, 1'b0); cyc(o); exp_q.push_back('{M_DATA, 32'hd000_0001});
        for (int k = 0; k < 5; k++) begin
            nid = 1'(k % 2);
            set_inst(~nid, 32'h1c00_0100 + 32'(k)); set_data(nid, 32'h0000_8100 + 32'(k), 1'b0);
            drive_resp(1'b1, o, e);
            checks++;
            if ({o.i_aok, o.d_aok, o.i_dok, o.d_dok, o.i_rd, o.d_rd} !==
                {~nid, nid, ~e.id, e.id, e.id ? 32'h0 : e.rdata, e.id ? e.rdata : 32'h0}) begin
                errors++; $display("FAIL pushpop%0d: got iaok=%b daok=%b iok=%b dok=%b ir=%h dr=%h, required push=%b id=%b rdata=%h",
                                   k, o.i_aok, o.d_aok, o.i_dok, o.d_dok, o.i_rd, o.d_rd, nid, e.id, e.rdata);
            end
            exp_q.push_back('{nid, 32'hd000_0010 + 32'(k)});
        end
        set_inst(1'b0, 32'h0); set_data(1'b1, 32'h0000_9000, 1'b1); set_slave(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(o);
            checks++;
            if ({o.s_req, o.d_aok} !== ((k < 2) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL pushpop_count%0d: got req=%b daok=%b, required %b",
                                   k, o.s_req, o.d_aok, (k < 2) ? 2'b11 : 2'b00);
            end
            if (k < 2) exp_q.push_back('{M_DATA, 32'he000_0000 + 32'(k)});
        end
        set_data(1'b0, 32'h0, 1'b0); set_slave(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive_resp(1'b0, o, e);
            checks++;
            if ({o.i_dok, o.d_dok, o.i_rd, o.d_rd} !== {~e.id, e.id, e.id ? 32'h0 : e.rdata, e.id ? e.rdata : 32'h0}) begin
                errors++; $display("FAIL pushpop_drain%0d: got iok=%b dok=%b ir=%h dr=%h, required id=%b rdata=%h",
                                   i, o.i_dok, o.d_dok, o.i_rd, o.d_rd, e.id, e.rdata);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o; exp_t e;
        set_data(1'b1, 32'h0000_a000, 1'b0); set_slave(1'b1, 1'b0, 32'h0);
        cyc(o); cyc(o);
        set_data(1'b0, 32'h0, 1'b0); set_inst(1'b1, 32'h1c00_0200); set_slave(1'b0, 1'b0, 32'h0);
        cyc(o);
        rstn = 1'b0;
        set_inst(1'b0, 32'h0);
        cyc(o);
        exp_q.delete();
        rstn = 1'b1;
        set_slave(1'b0, 1'b1, 32'hdead_0001);
        cyc(o);
        checks++;
        if (o !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: got %h, required 0", o);
        end
        set_data(1'b1, 32'h0000_b000, 1'b0); set_slave(1'b1, 1'b0, 32'h0);
        cyc(o);
        checks++;
        if ({o.d_aok, o.i_aok, o.s_addr} !== {2'b10, 32'h0000_b000}) begin
            errors++; $display("FAIL reset_mid_lock_clear: got daok=%b iaok=%b addr=%h, required 1 0 0000b000",
                               o.d_aok, o.i_aok, o.s_addr);
        end
        exp_q.push_back('{M_DATA, 32'hf00d_cafe});
        set_data(1'b0, 32'h0, 1'b0); set_slave(1'b0, 1'b0, 32'h0);
        drive_resp(1'b0, o, e);
        checks++;
        if ({o.i_dok, o.d_dok, o.i_rd, o.d_rd} !== {~e.id, e.id, e.id ? 32'h0 : e.rdata, e.id ? e.rdata : 32'h0}) begin
            errors++; $display("FAIL reset_mid_resp: got iok=%b dok=%b ir=%h dr=%h, required id=%b rdata=%h",
                               o.i_dok, o.d_dok, o.i_rd, o.d_rd, e.id, e.rdata);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_order();
        test_full();
        test_push_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
